// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-port memory slave.
// Holds the register-block offsets, the error-counter width and the address
// decoder used by both the read and write channels.
package data_mem_pkg;

    // Byte offsets of the register block, relative to MMIO_BASE.
    localparam logic [7:0] MTIME_LO_OFS    = 8'h00;
    localparam logic [7:0] MTIME_HI_OFS    = 8'h04;
    localparam logic [7:0] MTIMECMP_LO_OFS = 8'h08;
    localparam logic [7:0] MTIMECMP_HI_OFS = 8'h0C;
    localparam logic [7:0] TOHOST_OFS      = 8'h10;
    localparam logic [7:0] ERRCNT_OFS      = 8'h14;

    localparam int ERRCNT_W = 16;

    typedef enum logic [1:0] {
        RAM,
        MMIO_REG,
        UNMAPPED
    } region_e;

    // Classifies a byte address. Bits [1:0] are ignored, so every word inside
    // the register block from MTIME_LO up to ERRCNT is mapped.
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input logic [31:0] ram_bytes,
                                              input logic [31:0] mmio_base);
        logic [31:0] word_addr;
        logic [31:0] delta;
        word_addr = {addr[31:2], 2'b00};
        delta     = word_addr - mmio_base;
        if (word_addr < ram_bytes)
            return RAM;
        if ((word_addr >= mmio_base) && (delta <= {24'd0, ERRCNT_OFS}))
            return MMIO_REG;
        return UNMAPPED;
    endfunction

    // Low byte of the word-aligned offset from the register-block base.
    function automatic logic [7:0] reg_offset(input logic [31:0] addr,
                                              input logic [31:0] mmio_base);
        logic [31:0] delta;
        delta = {addr[31:2], 2'b00} - mmio_base;
        return delta[7:0];
    endfunction

endpackage

// File: rtl/data_mem_slave_timer.sv
// Machine timer: prescaler, 64-bit mtime, mtimecmp, the HI shadow used for
// atomic 64-bit reads, and the registered timer interrupt.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   wr_mtime_lo/hi           write strobes for the two mtime halves
//   wr_cmp_lo/hi             write strobes for the two mtimecmp halves
//   wdata                    write data
//   rd_lo                    MTIME_LO is being read this cycle
//   mtime_lo                 current mtime[31:0]
//   mtimecmp                 current compare value
//   hi_shadow                mtime[63:32] captured at the last LO read
//   timer_irq                registered (mtime >= mtimecmp)
module mem_timer #(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_mtime_lo,
    input  logic        wr_mtime_hi,
    input  logic        wr_cmp_lo,
    input  logic        wr_cmp_hi,
    input  logic [31:0] wdata,
    input  logic        rd_lo,
    output logic [31:0] mtime_lo,
    output logic [63:0] mtimecmp,
    output logic [31:0] hi_shadow,
    output logic        timer_irq
);

    localparam int             PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PS_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] prescaler;
    logic          tick;
    logic [63:0]   mtime;
    logic [63:0]   mtime_nxt;
    logic [63:0]   cmp_nxt;

    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        tick      = (prescaler == PS_LAST);
        mtime_nxt = tick ? (mtime + 64'd1) : mtime;
        // A written half takes the write data; the other half keeps its
        // normal increment, and the written half receives no carry.
        if (wr_mtime_lo) mtime_nxt[31:0]  = wdata;
        if (wr_mtime_hi) mtime_nxt[63:32] = wdata;
        cmp_nxt = mtimecmp;
        if (wr_cmp_lo) cmp_nxt[31:0]  = wdata;
        if (wr_cmp_hi) cmp_nxt[63:32] = wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            mtime     <= '0;
            mtimecmp  <= '1;
            hi_shadow <= '0;
            timer_irq <= 1'b0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            mtime     <= mtime_nxt;
            mtimecmp  <= cmp_nxt;
            if (rd_lo)
                hi_shadow <= mtime[63:32];
            // Compare post-update values so a compare write above mtime
            // drops the interrupt on the very next cycle.
            timer_irq <= (mtime_nxt >= cmp_nxt);
        end
    end

    assign mtime_lo = mtime[31:0];

endmodule

// File: rtl/data_mem_slave.sv
// Memory-side responder for the core's data port: word RAM, machine timer,
// TOHOST simulation-exit register and a saturating unmapped-access counter.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   raddr, re, rdata    read channel, zero latency (rdata combinational)
//   waddr, we, wdata    write channel, full-word writes at the rising edge
//   timer_irq           high while mtime >= mtimecmp (registered)
//   sim_done, sim_code  sticky exit flag and last value written to TOHOST
import data_mem_pkg::*;

module data_mem_slave #(
    parameter int          RAM_WORDS = 512,
    parameter logic [31:0] MMIO_BASE = 32'h0000_1000,
    parameter int          TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] raddr,
    input  logic        re,
    output logic [31:0] rdata,
    input  logic [31:0] waddr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic        timer_irq,
    output logic        sim_done,
    output logic [31:0] sim_code
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

    region_e             r_region;
    region_e             w_region;
    logic [7:0]          r_ofs;
    logic [7:0]          w_ofs;
    logic                r_reg;
    logic                w_reg;
    logic                wr_ram;
    logic                wr_tohost;
    logic                r_err;
    logic                w_err;
    logic [1:0]          err_inc;
    logic [ERRCNT_W:0]   err_sum;
    logic [ERRCNT_W-1:0] errcnt;
    logic [31:0]         ram [RAM_WORDS];

    logic [31:0] mtime_lo;
    logic [63:0] mtimecmp;
    logic [31:0] hi_shadow;

    assign r_region = decode_region(raddr, RAM_BYTES, MMIO_BASE);
    assign w_region = decode_region(waddr, RAM_BYTES, MMIO_BASE);
    assign r_ofs    = reg_offset(raddr, MMIO_BASE);
    assign w_ofs    = reg_offset(waddr, MMIO_BASE);

    assign r_reg     = re && (r_region == MMIO_REG);
    assign w_reg     = we && (w_region == MMIO_REG);
    assign wr_ram    = we && (w_region == RAM);
    assign wr_tohost = w_reg && (w_ofs == TOHOST_OFS);

    // ERRCNT is read-only, so a write to it counts as an unmapped access.
    assign r_err   = re && (r_region == UNMAPPED);
    assign w_err   = we && ((w_region == UNMAPPED) ||
                            ((w_region == MMIO_REG) && (w_ofs == ERRCNT_OFS)));
    assign err_inc = {1'b0, r_err} + {1'b0, w_err};
    assign err_sum = {1'b0, errcnt} + {{(ERRCNT_W - 1){1'b0}}, err_inc};

    mem_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_mtime_lo (w_reg && (w_ofs == MTIME_LO_OFS)),
        .wr_mtime_hi (w_reg && (w_ofs == MTIME_HI_OFS)),
        .wr_cmp_lo   (w_reg && (w_ofs == MTIMECMP_LO_OFS)),
        .wr_cmp_hi   (w_reg && (w_ofs == MTIMECMP_HI_OFS)),
        .wdata       (wdata),
        .rd_lo       (r_reg && (r_ofs == MTIME_LO_OFS)),
        .mtime_lo    (mtime_lo),
        .mtimecmp    (mtimecmp),
        .hi_shadow   (hi_shadow),
        .timer_irq   (timer_irq)
    );

    // NOTE: the RAM array has no reset; it maps onto plain memory and its
    // contents survive a reset of the control state.
    always_ff @(posedge clk) begin
        if (wr_ram)
            ram[waddr[AW+1:2]] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sim_done <= 1'b0;
            sim_code <= '0;
            errcnt   <= '0;
        end else begin
            if (wr_tohost) begin
                sim_code <= wdata;
                if (wdata != 32'd0)
                    sim_done <= 1'b1;
            end
            errcnt <= err_sum[ERRCNT_W] ? '1 : err_sum[ERRCNT_W-1:0];
        end
    end

    // Reads see pre-edge state, so a same-cycle write is visible next cycle.
    always_comb begin
        rdata = '0;
        if (re) begin
            case (r_region)
                RAM: rdata = ram[raddr[AW+1:2]];
                MMIO_REG: begin
                    case (r_ofs)
                        MTIME_LO_OFS:    rdata = mtime_lo;
                        MTIME_HI_OFS:    rdata = hi_shadow;
                        MTIMECMP_LO_OFS: rdata = mtimecmp[31:0];
                        MTIMECMP_HI_OFS: rdata = mtimecmp[63:32];
                        TOHOST_OFS:      rdata = sim_code;
                        ERRCNT_OFS:      rdata = {{(32 - ERRCNT_W){1'b0}}, errcnt};
                        default:         rdata = '0;
                    endcase
                end
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_slave.sv
// Scoreboard bench for data_mem_slave: the driver pushes hand-computed
// expectations as it drives each cycle; the monitor pops and compares them
// at the following falling edge.
module tb_data_mem_slave;

    localparam logic [31:0] MB      = 32'h0000_1000;
    localparam logic [31:0] A_MTLO  = MB + 32'h00;
    localparam logic [31:0] A_MTHI  = MB + 32'h04;
    localparam logic [31:0] A_CMPLO = MB + 32'h08;
    localparam logic [31:0] A_CMPHI = MB + 32'h0C;
    localparam logic [31:0] A_HOST  = MB + 32'h10;
    localparam logic [31:0] A_ERR   = MB + 32'h14;

    logic        clk;
    logic        rst_n;
    logic [31:0] raddr;
    logic        re;
    logic [31:0] rdata;
    logic [31:0] waddr;
    logic        we;
    logic [31:0] wdata;
    logic        timer_irq;
    logic        sim_done;
    logic [31:0] sim_code;

    typedef enum {K_RDATA, K_IRQ, K_DONE, K_CODE} kind_e;
    typedef struct {
        kind_e       kind;
        logic [31:0] exp;
        string       name;
    } item_t;

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;

    data_mem_slave #(
        .RAM_WORDS (512),
        .MMIO_BASE (MB),
        .TICK_DIV  (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .raddr     (raddr),
        .re        (re),
        .rdata     (rdata),
        .waddr     (waddr),
        .we        (we),
        .wdata     (wdata),
        .timer_irq (timer_irq),
        .sim_done  (sim_done),
        .sim_code  (sim_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Monitor: compares everything queued for the current cycle.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                it = sb.pop_front();
                case (it.kind)
                    K_RDATA: check(it.name, rdata, it.exp);
                    K_IRQ:   check(it.name, {31'd0, timer_irq}, it.exp);
                    K_DONE:  check(it.name, {31'd0, sim_done}, it.exp);
                    default: check(it.name, sim_code, it.exp);
                endcase
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic drive(input logic r, input logic [31:0] ra,
                         input logic w, input logic [31:0] wa, input logic [31:0] wd);
        @(posedge clk);
        #1;
        re    = r;
        raddr = ra;
        we    = w;
        waddr = wa;
        wdata = wd;
    endtask

    task automatic expect_item(input kind_e k, input logic [31:0] v, input string n);
        sb.push_back('{k, v, n});
    endtask

    initial begin
        rst_n = 1'b0;
        re = 1'b0; raddr = '0; we = 1'b0; waddr = '0; wdata = '0;
        #12 rst_n = 1'b1;

        // Reset state.
        drive(1, A_CMPLO, 0, 0, 0);
        expect_item(K_RDATA, 32'hFFFF_FFFF, "rst_cmplo");
        expect_item(K_IRQ, 0, "rst_irq");
        expect_item(K_DONE, 0, "rst_done");
        expect_item(K_CODE, 0, "rst_code");
        drive(1, A_ERR, 0, 0, 0);
        expect_item(K_RDATA, 0, "rst_errcnt");
        drive(1, A_MTHI, 0, 0, 0);
        expect_item(K_RDATA, 0, "rst_shadow");

        // RAM write/read and same-cycle read-old-value.
        drive(0, 0, 1, 32'h10, 32'hDEAD_BEEF);
        drive(1, 32'h10, 1, 32'h14, 32'h1234_5678);
        expect_item(K_RDATA, 32'hDEAD_BEEF, "ram_rd_10");
        drive(1, 32'h14, 1, 32'h14, 32'h55);
        expect_item(K_RDATA, 32'h1234_5678, "ram_same_cycle_old");
        drive(1, 32'h14, 0, 0, 0);
        expect_item(K_RDATA, 32'h55, "ram_next_cycle_new");
        drive(0, 32'h10, 0, 0, 0);
        expect_item(K_RDATA, 0, "ram_re_low");

        // TOHOST.
        drive(0, 0, 1, A_HOST, 32'd0);
        drive(0, 0, 1, A_HOST, 32'd1);
        expect_item(K_DONE, 0, "host_zero_done");
        expect_item(K_CODE, 0, "host_zero_code");
        drive(0, 0, 1, A_HOST, 32'd0);
        expect_item(K_DONE, 1, "host_one_done");
        expect_item(K_CODE, 1, "host_one_code");
        drive(1, A_HOST, 0, 0, 0);
        expect_item(K_DONE, 1, "host_sticky_done");
        expect_item(K_CODE, 0, "host_rezero_code");
        expect_item(K_RDATA, 0, "host_read");

        // Unmapped accesses: 3 reads, then read+write both unmapped -> 5.
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h2000, 0, 0, 0);
            expect_item(K_RDATA, 0, "unmapped_rd");
        end
        drive(1, 32'h2000, 1, 32'h2004, 32'hAAAA_AAAA);
        drive(1, A_ERR, 1, A_ERR, 32'h0000_FFFF);
        expect_item(K_RDATA, 5, "errcnt_5");
        drive(1, A_ERR, 0, 0, 0);
        expect_item(K_RDATA, 6, "errcnt_ro_write");

        // Timer: restart mtime at 0, then set compare to 20.
        drive(0, 0, 1, A_MTLO, 32'd0);
        drive(0, 0, 1, A_CMPHI, 32'd0);
        drive(0, 0, 1, A_CMPLO, 32'd20);
        // In cycle n (counting from the MTIME_LO write) mtime reads n-1.
        for (int n = 3; n <= 24; n++) begin
            drive(1, A_MTLO, 0, 0, 0);
            expect_item(K_RDATA, 32'(n - 1), "mtime_count");
            expect_item(K_IRQ, (n - 1 >= 20) ? 32'd1 : 32'd0, "irq_vs_mtime");
        end
        drive(0, 0, 1, A_CMPLO, 32'd1000);
        expect_item(K_IRQ, 1, "irq_before_cmp_raise");
        drive(0, 0, 0, 0, 0);
        expect_item(K_IRQ, 0, "irq_after_cmp_raise");

        // Atomic 64-bit read across a carry into the high word.
        drive(0, 0, 1, A_MTHI, 32'd0);
        drive(0, 0, 1, A_MTLO, 32'hFFFF_FFFE);
        drive(1, A_MTLO, 0, 0, 0);
        expect_item(K_RDATA, 32'hFFFF_FFFE, "atomic_lo");
        drive(1, A_MTHI, 0, 0, 0);
        expect_item(K_RDATA, 0, "atomic_hi");
        drive(1, A_MTHI, 0, 0, 0);
        expect_item(K_RDATA, 0, "atomic_hi_after_carry");
        drive(1, A_MTLO, 0, 0, 0);
        expect_item(K_RDATA, 1, "lo_after_carry");
        drive(1, A_MTHI, 0, 0, 0);
        expect_item(K_RDATA, 1, "hi_after_new_lo_read");
        expect_item(K_IRQ, 1, "irq_high_before_reset");

        // Asynchronous reset between clock edges.
        drive(1, A_MTLO, 0, 0, 0);
        #1 rst_n = 1'b0;
        expect_item(K_IRQ, 0, "async_rst_irq");
        expect_item(K_DONE, 0, "async_rst_done");
        expect_item(K_CODE, 0, "async_rst_code");
        expect_item(K_RDATA, 0, "async_rst_mtime");
        drive(1, A_ERR, 0, 0, 0);
        expect_item(K_RDATA, 0, "async_rst_errcnt");
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        drive(1, 32'h10, 0, 0, 0);
        expect_item(K_RDATA, 32'hDEAD_BEEF, "ram_kept_10");
        drive(1, 32'h14, 0, 0, 0);
        expect_item(K_RDATA, 32'h55, "ram_kept_14");

        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_slave.md
Name: data_mem_slave

Overview:
- Memory-side responder for the CPU core's data-port master (raddr/re/rdata read channel, waddr/we/wdata write channel).
- Contents:
  - word-wide data RAM (2 KB default);
  - memory-mapped machine timer (mtime/mtimecmp) driving a timer interrupt;
  - tohost register that ends simulation;
  - saturating counter of accesses to unmapped addresses.
- Instantiated next to the core in the SoC/testbench wrapper, on the external side of the core's data bridge.

Parameters:
- RAM_WORDS, 512, RAM depth in 32-bit words (power of 2); RAM occupies byte addresses 0 .. 4*RAM_WORDS-1.
- MMIO_BASE, 32'h0000_1000, base address of the register block.
- TICK_DIV, 1, clock cycles per mtime increment (≥1).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- raddr  in  32  read byte address; bits [1:0] ignored.
- re  in  1  read enable.
- rdata  out  32  read data, combinational.
- waddr  in  32  write byte address; bits [1:0] ignored.
- we  in  1  write enable, full-word write.
- wdata  in  32  write data.
- timer_irq  out  1  registered, high while mtime ≥ mtimecmp.
- sim_done  out  1  sticky, set by a nonzero write to TOHOST.
- sim_code  out  32  value written to TOHOST.

Behaviour:
- Reset: one clock; asynchronous active-low reset (rst_n).
  - Cleared: timer_irq=0, sim_done=0, sim_code=0, mtime=0, hi_shadow=0, prescaler=0, errcnt=0.
  - mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF.
  - RAM contents not reset.
- Address map (word offsets from MMIO_BASE):
  - +0x00 MTIME_LO, RW.
  - +0x04 MTIME_HI, RW; reads return hi_shadow.
  - +0x08 MTIMECMP_LO, RW.
  - +0x0C MTIMECMP_HI, RW.
  - +0x10 TOHOST, RW.
  - +0x14 ERRCNT, RO, 16-bit zero-extended.
  - All other addresses are unmapped.
- Read channel:
  - Zero latency; rdata is a pure function of raddr, re and current state.
  - re=0 → rdata=0. Unmapped read → 0.
- Write channel:
  - Takes effect at the rising edge with we=1.
  - Writes to RO or unmapped addresses are ignored.
  - Reads and writes are independent and may occur in the same cycle.
  - Same-cycle read and write to the same address: rdata returns the OLD value; the new value is visible from the next cycle.
- Error counter:
  - errcnt increments by 1 per cycle for each unmapped access (re to unmapped, we to unmapped or ERRCNT).
  - Both channels unmapped in the same cycle → +2.
  - Saturates at 16'hFFFF.
- mtime:
  - Prescaler counts 0..TICK_DIV-1; mtime increments by 1 when the prescaler wraps.
  - mtime wraps 2^64-1 → 0.
  - A write to MTIME_LO/HI replaces that half; a write and a tick in the same cycle: the write wins, the other half still increments normally (no carry into the written half).
- Atomic 64-bit read: on an edge with re=1 and raddr=MTIME_LO, hi_shadow ← mtime[63:32] (the value at the time of the LO read).
- timer_irq:
  - Registered from (mtime ≥ mtimecmp) using post-update values.
  - Asserted the cycle after the condition becomes true; deasserts one cycle after mtimecmp is written above mtime.
- TOHOST:
  - A write stores wdata into sim_code.
  - A nonzero write sets sim_done=1, sticky until reset.
  - A zero write updates sim_code only.
- RAM: index = addr[log2(RAM_WORDS)+1:2]; in range iff addr < 4*RAM_WORDS.

Decomposition:
- Package data_mem_pkg:
  - register offset constants (MTIME_LO_OFS … ERRCNT_OFS);
  - ERRCNT width constant;
  - address-decode function returning region enum {RAM, MMIO_REG, UNMAPPED}.
- Sub-module mem_timer: prescaler, mtime, mtimecmp, hi_shadow, timer_irq.
  - Inputs: decoded write strobes, wdata, LO-read strobe.
  - Outputs: register read values, timer_irq.
- Top: decode, RAM array, TOHOST, errcnt, rdata mux.

Test Plan:
- RAM: we at 0x10 data 0xDEADBEEF, then re 0x10 → rdata 0xDEADBEEF; same-cycle write 0x55 / read 0x14 → old value, next cycle 0x55.
- Timer, TICK_DIV=1: write MTIMECMP_HI=0, MTIMECMP_LO=20 → timer_irq rises once mtime=20, one cycle later; write MTIMECMP_LO=1000 → irq low next cycle.
- Atomic read: write MTIME_HI=0, MTIME_LO=0xFFFF_FFFE; read LO one cycle later → hi_shadow=0; subsequent HI read → 0 even after carry into mtime[63:32].
- Unmapped: re 0x2000 for 3 cycles plus one cycle with re and we both unmapped → ERRCNT read = 5; write to ERRCNT ignored (+1 → 6).
- TOHOST: write 0 → sim_done=0, sim_code=0; write 1 → sim_done=1, sim_code=1; later write 0 → sim_done remains 1.
- Reset mid-run: assert rst_n=0 asynchronously while timer_irq=1 → timer_irq, sim_done, mtime, errcnt all 0 immediately; RAM data preserved.
